// File: rtl/fifo_drain_checker_pkg.sv
// rtl/fifo_drain_checker_pkg.sv - shared state type, parameter defaults and helpers for fifo_drain_checker
package fifo_drain_checker_pkg;

    localparam int          DEF_DATA_W    = 16;
    localparam logic [15:0] DEF_SEED      = 16'h0000;
    localparam int          DEF_MAX_BURST = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Error counter sticks at its ceiling instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry in-order output buffer with push/pop/count interface
module skid_buf2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop   = pop && (count != 2'd0);
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain_checker.sv
// rtl/fifo_drain_checker.sv - bursty FIFO drain with credit-limited reads and sequence checking
module fifo_drain_checker
    import fifo_drain_checker_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(DEF_SEED),
    parameter int                MAX_BURST = DEF_MAX_BURST
) (
    input  logic              rd_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       word_cnt,
    output logic [7:0]        err_cnt,
    output logic              seq_err,
    output logic              busy
);

    localparam int                 BURST_W    = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    state_t             state;
    logic [BURST_W-1:0] burst_cnt;
    logic               inflight;
    logic [DATA_W-1:0]  expected;
    logic [1:0]         buf_count;
    logic               pop;
    logic [2:0]         credit_used;

    assign out_valid   = (buf_count != 2'd0);
    assign pop         = out_valid && out_ready;
    // A word leaving this cycle frees its slot, which keeps back-to-back reads at full rate.
    assign credit_used = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en       = (state == ST_READ) && !empty && (credit_used < 3'd2);
    assign busy        = (state != ST_IDLE);

    skid_buf2 #(
        .W(DATA_W)
    ) u_buf (
        .clk       (rd_clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (buf_count)
    );

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (enable) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!enable) begin
                        state     <= ST_DRAIN;
                        burst_cnt <= '0;
                    end else if (rd_en && (burst_cnt == BURST_LAST)) begin
                        state     <= ST_GAP;
                        burst_cnt <= '0;
                    end else if (rd_en) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end else begin
                        burst_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    burst_cnt <= '0;
                    state     <= enable ? ST_READ : ST_DRAIN;
                end
                ST_DRAIN: begin
                    burst_cnt <= '0;
                    if (enable) begin
                        state <= ST_READ;
                    end else if (!inflight && (buf_count == 2'd0)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Every word landing in the buffer is checked; a mismatch resyncs to that word.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
            expected <= SEED;
            word_cnt <= 16'd0;
            err_cnt  <= 8'd0;
            seq_err  <= 1'b0;
        end else begin
            inflight <= rd_en;
            seq_err  <= 1'b0;
            if (inflight) begin
                word_cnt <= word_cnt + 16'd1;
                expected <= fifo_data + DATA_W'(1);
                if (fifo_data != expected) begin
                    seq_err <= 1'b1;
                    err_cnt <= sat_inc8(err_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_checker.sv
// tb/tb_fifo_drain_checker.sv - randomized and directed bench for fifo_drain_checker against a queue model
module tb_fifo_drain_checker;

    localparam int          MB     = 8;
    localparam logic [15:0] SEED_V = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        empty;
    logic [15:0] fifo_data;
    logic        rd_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_cnt;
    logic [7:0]  err_cnt;
    logic        seq_err;
    logic        busy;

    always #5 clk = ~clk;

    fifo_drain_checker #(
        .DATA_W    (16),
        .SEED      (SEED_V),
        .MAX_BURST (MB)
    ) dut (
        .rd_clk    (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .empty     (empty),
        .fifo_data (fifo_data),
        .rd_en     (rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt),
        .seq_err   (seq_err),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] mq[$];
    logic        m_inflight;
    logic [15:0] m_word;
    logic [15:0] m_exp;
    int          m_wc;
    int          m_err;
    logic        m_seq;
    bit          chk_on = 1'b0;

    int          run_len;
    int          rd_cnt;
    logic [15:0] dlv[$];
    bit          rd_log[$];
    int          seq_pulses;
    int          seq_at;
    logic [15:0] gen_next;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) check("out_data", out_data, mq[0]);
            check("word_cnt", word_cnt, m_wc % 65536);
            check("err_cnt", err_cnt, m_err);
            check("seq_err", seq_err, m_seq);
        end
    end

    // One clock of external FIFO + behavioural model; entered and left at negedge+2.
    task automatic cyc();
        logic took;
        logic popped;
        #1;
        took   = rd_en;
        popped = out_ready && (mq.size() != 0);
        if (took) begin
            check("rd_en_nonempty", empty, 0);
            check("rd_en_credit", (int'(m_inflight) + mq.size() - int'(popped)) < 2, 1);
            check("rd_en_busy", busy, 1);
            run_len++;
            rd_cnt++;
            check("burst_len", run_len <= MB, 1);
        end else begin
            run_len = 0;
        end
        rd_log.push_back(took);
        if (out_valid && out_ready) dlv.push_back(out_data);
        @(posedge clk);
        #1;
        if (popped) void'(mq.pop_front());
        m_seq = 1'b0;
        if (m_inflight) begin
            mq.push_back(m_word);
            if (m_word != m_exp) begin
                m_seq = 1'b1;
                if (m_err < 255) m_err++;
            end
            m_exp = m_word + 16'd1;
            m_wc++;
        end
        m_inflight = took;
        if (took && fifo_q.size() != 0) begin
            m_word    = fifo_q.pop_front();
            fifo_data = m_word;
        end
        empty = (fifo_q.size() == 0);
        @(negedge clk);
        #2;
        if (seq_err) begin
            seq_pulses++;
            seq_at = word_cnt;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_busy", busy, 0);
        mq.delete();
        m_inflight = 1'b0;
        m_exp      = SEED_V;
        m_wc       = 0;
        m_err      = 0;
        m_seq      = 1'b0;
        run_len    = 0;
        @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic fresh();
        enable    = 1'b0;
        out_ready = 1'b0;
        do_reset();
        fifo_q.delete();
        empty = 1'b1;
        dlv.delete();
        rd_log.delete();
        rd_cnt     = 0;
        seq_pulses = 0;
        seq_at     = -1;
    endtask

    task automatic load_seq(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 16'(i));
        empty = (fifo_q.size() == 0);
    endtask

    task automatic first_last(output int f, output int l);
        f = -1;
        l = -1;
        for (int i = 0; i < rd_log.size(); i++) begin
            if (rd_log[i]) begin
                if (f < 0) f = i;
                l = i;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  f;
        int  l;
        bit  seen;
        logic [15:0] w;

        reset_n    = 1'b0;
        enable     = 1'b0;
        empty      = 1'b1;
        out_ready  = 1'b0;
        fifo_data  = 16'd0;
        m_inflight = 1'b0;
        m_word     = 16'd0;
        m_exp      = SEED_V;
        m_wc       = 0;
        m_err      = 0;
        m_seq      = 1'b0;
        @(negedge clk);
        #2;

        // Four preloaded words drain back to back.
        fresh();
        chk_on = 1'b1;
        load_seq(4, 16'd0);
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (10) cyc();
        first_last(f, l);
        check("t1_reads", rd_cnt, 4);
        check("t1_consecutive", l - f, 3);
        check("t1_dlv_n", dlv.size(), 4);
        for (int i = 0; i < dlv.size() && i < 4; i++) check("t1_dlv", dlv[i], i);
        check("t1_word_cnt", word_cnt, 4);
        check("t1_err_cnt", err_cnt, 0);
        enable = 1'b0;
        repeat (3) cyc();
        check("t1_idle", busy, 0);

        // Twenty words: a one-cycle gap after the 8th and 16th reads.
        fresh();
        load_seq(20, 16'd0);
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (40) cyc();
        first_last(f, l);
        check("t2_reads", rd_cnt, 20);
        check("t2_span", l - f, 21);
        for (int k = 0; k < 22 && f >= 0 && (f + k) < rd_log.size(); k++)
            check("t2_pattern", rd_log[f + k], !(k == 8 || k == 17));
        check("t2_word_cnt", word_cnt, 20);

        // Stream 0,1,5,6: a single error, flagged on the third word.
        fresh();
        fifo_q.push_back(16'd0);
        fifo_q.push_back(16'd1);
        fifo_q.push_back(16'd5);
        fifo_q.push_back(16'd6);
        empty     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (12) cyc();
        check("t3_pulses", seq_pulses, 1);
        check("t3_pulse_word", seq_at, 3);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_word_cnt", word_cnt, 4);

        // Downstream stalled: reads stop at two, then everything drains in order.
        fresh();
        load_seq(10, 16'd0);
        enable = 1'b1;
        repeat (20) cyc();
        check("t4_stall_reads", rd_cnt, 2);
        check("t4_valid_held", out_valid, 1);
        check("t4_head", out_data, 0);
        out_ready = 1'b1;
        repeat (40) cyc();
        check("t4_dlv_n", dlv.size(), 10);
        for (int i = 0; i < dlv.size() && i < 10; i++) check("t4_dlv", dlv[i], i);
        check("t4_word_cnt", word_cnt, 10);

        // Enable dropped with a read outstanding: drain it, then go idle.
        fresh();
        load_seq(6, 16'd0);
        enable    = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            seen = rd_log[rd_log.size() - 1];
        end
        check("t5_read_seen", seen, 1);
        enable = 1'b0;
        cyc();
        check("t5_drain_busy", busy, 1);
        check("t5_drain_rd_en", rd_en, 0);
        for (int i = 0; i < 10 && busy; i++) cyc();
        check("t5_idle", busy, 0);
        check("t5_words", word_cnt, rd_cnt);
        check("t5_dlv_n", dlv.size(), rd_cnt);

        // Reset mid-burst; the returning word must be discarded.
        fresh();
        load_seq(20, 16'd0);
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (5) cyc();
        do_reset();
        repeat (12) cyc();
        enable = 1'b0;
        repeat (6) cyc();

        // Every word wrong: error counter saturates.
        fresh();
        for (int i = 0; i < 300; i++) fifo_q.push_back(16'hA5A5);
        empty     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (380) cyc();
        check("t7_err_sat", err_cnt, 255);
        check("t7_word_cnt", word_cnt, 300);

        // Random traffic, mostly in sequence with occasional jumps.
        fresh();
        gen_next = SEED_V;
        enable   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) begin
                    w = ($urandom_range(0, 15) == 0) ? 16'($urandom) : gen_next;
                    fifo_q.push_back(w);
                    gen_next = w + 16'd1;
                end
            end
            empty = (fifo_q.size() == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            out_ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                do_reset();
                gen_next = SEED_V;
                fifo_q.delete();
                empty = 1'b1;
            end
            cyc();
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        repeat (10) cyc();
        check("end_idle", busy, 0);
        check("end_drained", out_valid, 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_drain_checker.md
FIFO_DRAIN_CHECKER -- requirements
Module: fifo_drain_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FIFO read-data width.
REQ-002 SHALL have parameter SEED, default 16'h0000, expected value of the first word after reset.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive rd_en cycles before a mandatory 1-cycle gap.
REQ-004 SHALL have ports, in this order; one clock, reset asynchronous active-low:
- rd_clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  level; 1 = drain FIFO.
- empty  input  1  FIFO empty flag, rd_clk domain.
- fifo_data  input  DATA_W  FIFO data_out, valid exactly one cycle after an accepted rd_en.
- rd_en  output  1  FIFO read strobe.
- out_data  output  DATA_W  head of output buffer.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
- word_cnt  output  16  words received, wraps.
- err_cnt  output  8  sequence errors, saturates at 255.
- seq_err  output  1  one-cycle pulse per mismatching word.
- busy  output  1  high when state != IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, READ, GAP, DRAIN.
REQ-006 IDLE->READ when enable=1; READ->DRAIN when enable=0; READ->GAP after MAX_BURST consecutive rd_en cycles; GAP->READ after exactly 1 cycle, or GAP->DRAIN if enable=0.
REQ-007 DRAIN->IDLE when no read is in flight and the output buffer is empty; DRAIN->READ if enable returns to 1.
REQ-008 rd_en SHALL be high only in READ, with empty=0, and with (in-flight reads + buffered words) < 2.
REQ-009 rd_en SHALL be combinational in empty, so rd_en drops in the same cycle empty rises.
REQ-010 Each rd_en SHALL set a 1-bit in-flight flag; on the following cycle fifo_data is pushed into a 2-entry output buffer.
REQ-011 out_valid SHALL equal buffer non-empty; out_data SHALL be the oldest entry.
REQ-012 Push and pop in the same cycle SHALL leave occupancy unchanged and keep order.
REQ-013 The credit rule SHALL make buffer overflow impossible; out_ready low indefinitely SHALL stall rd_en, never drop data.
REQ-014 Each pushed word SHALL be compared with the expected register.
- match: expected <= word+1, modulo 2^DATA_W.
- mismatch: seq_err pulses the same cycle, err_cnt increments unless it is 255, expected <= word+1 (resync).
REQ-015 word_cnt SHALL increment once per pushed word and wrap 16'hFFFF->0.
REQ-016 The burst counter SHALL clear on GAP, DRAIN, IDLE, and on any READ cycle where rd_en=0.

Reset
REQ-017 On reset_n low, immediately:
- state=IDLE, rd_en=0, out_valid=0, out_data=0, buffer empty, in-flight cleared.
- word_cnt=0, err_cnt=0, seq_err=0, busy=0, expected=SEED.
REQ-018 Reset mid-operation SHALL discard buffered and in-flight words; a FIFO word returning after reset release SHALL be ignored.
REQ-019 Release SHALL be synchronised to rd_clk by the integrator; the block adds no synchroniser.

Structure
REQ-020 A shared package SHALL hold the FSM state enum and the defaults for DATA_W, SEED, MAX_BURST.
REQ-021 The 2-entry output buffer SHALL be a sub-module, skid_buf2, with push/pop/count ports.
REQ-022 The sequence checker and counters SHALL stay in the top module.

Verification
REQ-023 FIFO preloaded with 0..3, enable=1, out_ready=1 -> rd_en in 4 consecutive cycles; out_data 0,1,2,3; word_cnt=4; err_cnt=0.
REQ-024 20 words, MAX_BURST=8, out_ready=1 -> rd_en low exactly one cycle after the 8th and 16th reads; word_cnt=20.
REQ-025 Stream 0,1,5,6 -> one seq_err pulse, on word 5; err_cnt=1; word 6 is no error.
REQ-026 out_ready=0 with 10 words queued -> at most 2 rd_en pulses, out_valid held, out_data=0; out_ready=1 -> all 10 delivered in order.
REQ-027 Other boundaries:
- enable dropped while a read is in flight -> state DRAIN, in-flight word still delivered, then IDLE with busy=0.
- reset_n asserted mid-burst -> all outputs zero within the same cycle.
- 300 forced mismatches -> err_cnt=255.
